// File: rtl/ltssm_pkg.sv
// Shared types and symbol constants for the LTSSM ordered-set transmit path.
package ltssm_pkg;

    typedef enum logic {
        OS_TS1,
        OS_TS2
    } os_type_e;

    typedef enum logic [1:0] {
        IDLE,
        TS,
        SKP
    } os_tx_st_e;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] TS1_ID  = 8'h4A;
    localparam logic [7:0] TS2_ID  = 8'h45;

    localparam logic [3:0] TS_LAST_IDX  = 4'd15;
    localparam logic [3:0] SKP_LAST_IDX = 4'd3;

    function automatic logic [7:0] tsIdSym(input os_type_e osType);
        return (osType == OS_TS2) ? TS2_ID : TS1_ID;
    endfunction

endpackage

// File: rtl/os_tx_scheduler_skp_interval_timer.sv
// Beat counter that pulses wrap_o on the beat that completes one SKP interval.
module skp_interval_timer #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic beat_i,
    output logic wrap_o
);

    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o = beat_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/os_tx_scheduler.sv
// Ordered-set transmit scheduler: TS1/TS2 sequencing, SKP insertion at OS
// boundaries and a saturating completed-TS counter for the Polling exit rule.
module os_tx_scheduler
    import ltssm_pkg::*;
#(
    parameter int         SKP_INTERVAL = 1180,
    parameter int         TS_CNT_MAX   = 1024,
    parameter logic [7:0] N_FTS        = 8'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        os_type_i,
    input  logic [4:0]  speeds_i,
    input  logic        speed_change_i,
    input  logic [7:0]  train_ctrl_i,
    input  logic        cnt_clr_i,
    output logic [7:0]  sym_o,
    output logic        sym_k_o,
    output logic        sym_valid_o,
    input  logic        sym_ready_i,
    output logic        os_done_o,
    output logic [10:0] ts_cnt_o,
    output logic        ts_cnt_done_o
);

    localparam logic [10:0] TS_MAX = 11'(TS_CNT_MAX);

    os_tx_st_e   state_q, state_d;
    logic [3:0]  symIdx_q, symIdx_d;
    logic        skpPending_q, skpPending_d;
    logic [10:0] tsCnt_q, tsCnt_d;
    os_type_e    curType_q, curType_d;
    os_type_e    prevType_q, prevType_d;
    logic [4:0]  speedsLat_q, speedsLat_d;
    logic        speedChgLat_q, speedChgLat_d;
    logic [7:0]  trainCtrlLat_q, trainCtrlLat_d;

    logic beat;
    logic skpWrap;
    logic tsLast;
    logic skpLast;

    assign beat    = sym_valid_o && sym_ready_i;
    assign tsLast  = beat && (state_q == TS)  && (symIdx_q == TS_LAST_IDX);
    assign skpLast = beat && (state_q == SKP) && (symIdx_q == SKP_LAST_IDX);

    skp_interval_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .beat_i(beat),
        .wrap_o(skpWrap)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            symIdx_q       <= '0;
            skpPending_q   <= 1'b0;
            tsCnt_q        <= '0;
            curType_q      <= OS_TS1;
            prevType_q     <= OS_TS1;
            speedsLat_q    <= '0;
            speedChgLat_q  <= 1'b0;
            trainCtrlLat_q <= '0;
        end else begin
            state_q        <= state_d;
            symIdx_q       <= symIdx_d;
            skpPending_q   <= skpPending_d;
            tsCnt_q        <= tsCnt_d;
            curType_q      <= curType_d;
            prevType_q     <= prevType_d;
            speedsLat_q    <= speedsLat_d;
            speedChgLat_q  <= speedChgLat_d;
            trainCtrlLat_q <= trainCtrlLat_d;
        end
    end

    // A wrap seen on the final beat of a TS is still honoured at that boundary.
    always_comb begin
        state_d        = state_q;
        symIdx_d       = symIdx_q;
        skpPending_d   = skpPending_q | skpWrap;
        tsCnt_d        = tsCnt_q;
        curType_d      = curType_q;
        prevType_d     = prevType_q;
        speedsLat_d    = speedsLat_q;
        speedChgLat_d  = speedChgLat_q;
        trainCtrlLat_d = trainCtrlLat_q;

        case (state_q)
            IDLE: begin
                symIdx_d = '0;
                if (en_i) begin
                    state_d = TS;
                end
            end
            TS: begin
                if (beat) begin
                    if (symIdx_q == 4'd0) begin
                        curType_d      = os_type_e'(os_type_i);
                        speedsLat_d    = speeds_i;
                        speedChgLat_d  = speed_change_i;
                        trainCtrlLat_d = train_ctrl_i;
                    end
                    if (symIdx_q == TS_LAST_IDX) begin
                        symIdx_d = '0;
                        if (skpPending_q || skpWrap) begin
                            state_d = SKP;
                        end else if (en_i) begin
                            state_d = TS;
                        end else begin
                            state_d      = IDLE;
                            skpPending_d = 1'b0;
                        end
                    end else begin
                        symIdx_d = symIdx_q + 4'd1;
                    end
                end
            end
            SKP: begin
                if (beat) begin
                    if (symIdx_q == SKP_LAST_IDX) begin
                        symIdx_d     = '0;
                        skpPending_d = skpWrap && en_i;
                        state_d      = en_i ? TS : IDLE;
                    end else begin
                        symIdx_d = symIdx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tsLast) begin
            prevType_d = curType_q;
            if (curType_q != prevType_q) begin
                tsCnt_d = 11'd1;
            end else if (tsCnt_q < TS_MAX) begin
                tsCnt_d = tsCnt_q + 11'd1;
            end
        end
        if (cnt_clr_i) begin
            tsCnt_d = '0;
        end
    end

    always_comb begin
        sym_valid_o = 1'b0;
        sym_o       = 8'h00;
        sym_k_o     = 1'b0;
        case (state_q)
            TS: begin
                sym_valid_o = 1'b1;
                case (symIdx_q)
                    4'd0: begin
                        sym_o   = SYM_COM;
                        sym_k_o = 1'b1;
                    end
                    4'd1, 4'd2: begin
                        sym_o   = SYM_PAD;
                        sym_k_o = 1'b1;
                    end
                    4'd3:    sym_o = N_FTS;
                    4'd4:    sym_o = {speedChgLat_q, 1'b0, speedsLat_q, 1'b0};
                    4'd5:    sym_o = trainCtrlLat_q;
                    default: sym_o = tsIdSym(curType_q);
                endcase
            end
            SKP: begin
                sym_valid_o = 1'b1;
                sym_k_o     = 1'b1;
                sym_o       = (symIdx_q == 4'd0) ? SYM_COM : SYM_SKP;
            end
            default: begin
                sym_valid_o = 1'b0;
            end
        endcase
    end

    assign os_done_o     = tsLast;
    assign ts_cnt_o      = tsCnt_q;
    assign ts_cnt_done_o = (tsCnt_q == TS_MAX);

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Directed bench for os_tx_scheduler; a second instance uses a short SKP interval.
module tb_os_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        osType;
    logic [4:0]  speeds;
    logic        speedChg;
    logic [7:0]  trainCtrl;
    logic        cntClr;
    logic        ready;

    logic [7:0]  sym,      sym40;
    logic        symK,     symK40;
    logic        symValid, symValid40;
    logic        osDone,   osDone40;
    logic [10:0] tsCnt,    tsCnt40;
    logic        tsCntDone, tsCntDone40;

    int testCnt = 0;
    int failCnt = 0;

    os_tx_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .os_type_i     (osType),
        .speeds_i      (speeds),
        .speed_change_i(speedChg),
        .train_ctrl_i  (trainCtrl),
        .cnt_clr_i     (cntClr),
        .sym_o         (sym),
        .sym_k_o       (symK),
        .sym_valid_o   (symValid),
        .sym_ready_i   (ready),
        .os_done_o     (osDone),
        .ts_cnt_o      (tsCnt),
        .ts_cnt_done_o (tsCntDone)
    );

    os_tx_scheduler #(
        .SKP_INTERVAL(40)
    ) dut40 (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .os_type_i     (osType),
        .speeds_i      (speeds),
        .speed_change_i(speedChg),
        .train_ctrl_i  (trainCtrl),
        .cnt_clr_i     (cntClr),
        .sym_o         (sym40),
        .sym_k_o       (symK40),
        .sym_valid_o   (symValid40),
        .sym_ready_i   (ready),
        .os_done_o     (osDone40),
        .ts_cnt_o      (tsCnt40),
        .ts_cnt_done_o (tsCntDone40)
    );

    // Expected {K, byte} of TS symbol idx, built from the symbol table.
    function automatic logic [8:0] expTs(input int idx, input logic typ,
                                         input logic [4:0] spd, input logic sc,
                                         input logic [7:0] tc);
        case (idx)
            0:       return {1'b1, 8'hBC};
            1, 2:    return {1'b1, 8'hF7};
            3:       return {1'b0, 8'h00};
            4:       return {1'b0, sc, 1'b0, spd, 1'b0};
            5:       return {1'b0, tc};
            default: return {1'b0, (typ ? 8'h45 : 8'h4A)};
        endcase
    endfunction

    function automatic logic [8:0] expSkp(input int idx);
        return (idx == 0) ? {1'b1, 8'hBC} : {1'b1, 8'h1C};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enVal, input logic readyVal);
        en    = enVal;
        ready = readyVal;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCnt++;
        assert (observed === expected)
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst    = 1'b1;
        cntClr = 1'b0;
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait until os_done_o is seen high in the current cycle.
    task automatic waitDone(input string tag);
        int n = 0;
        while (!osDone && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(osDone), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [1:0] segs [8];
        int         acc;
        int         cyc;
        logic       stallPrev;
        logic [8:0] symPrev;

        rst       = 1'b1;
        en        = 1'b0;
        ready     = 1'b1;
        cntClr    = 1'b0;
        osType    = 1'b0;
        speeds    = 5'b00011;
        speedChg  = 1'b0;
        trainCtrl = 8'h5A;

        doReset();
        checkOutput("rst_valid",   32'(symValid),  32'd0);
        checkOutput("rst_sym",     32'(sym),       32'd0);
        checkOutput("rst_k",       32'(symK),      32'd0);
        checkOutput("rst_done",    32'(osDone),    32'd0);
        checkOutput("rst_cnt",     32'(tsCnt),     32'd0);
        checkOutput("rst_cntdone", 32'(tsCntDone), 32'd0);

        // Test 1: basic TS1 with no stalls; mid-OS field changes must not leak.
        applyStimulus(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t1_sym%0d", i), 32'({symK, sym}),
                        32'(expTs(i, 1'b0, 5'b00011, 1'b0, 8'h5A)));
            checkOutput($sformatf("t1_valid%0d", i), 32'(symValid), 32'd1);
            checkOutput($sformatf("t1_done%0d", i), 32'(osDone), 32'(i == 15));
            if (i == 1) begin
                speeds    = 5'b11111;
                trainCtrl = 8'hFF;
            end
            tick();
        end
        checkOutput("t1_cnt", 32'(tsCnt), 32'd1);
        checkOutput("t1_next_com", 32'({symK, sym}), 32'h1BC);
        speeds    = 5'b00011;
        trainCtrl = 8'h5A;

        // Test 2: random backpressure over 5 TS1.
        doReset();
        applyStimulus(1'b1, 1'b0);
        tick();
        acc       = 0;
        cyc       = 0;
        stallPrev = 1'b0;
        symPrev   = '0;
        while (acc < 80 && cyc < 2000) begin
            ready = 1'($urandom_range(0, 1));
            #1;
            if (stallPrev) begin
                checkOutput("t2_hold", 32'({symK, sym}), 32'(symPrev));
            end
            if (symValid && ready) begin
                checkOutput($sformatf("t2_sym%0d", acc), 32'({symK, sym}),
                            32'(expTs(acc % 16, 1'b0, 5'b00011, 1'b0, 8'h5A)));
                acc++;
            end
            stallPrev = symValid && !ready;
            symPrev   = {symK, sym};
            if (acc == 80) begin
                en = 1'b0;
            end
            tick();
            cyc++;
        end
        checkOutput("t2_accepted", 32'(acc), 32'd80);
        checkOutput("t2_cnt", 32'(tsCnt), 32'd5);
        checkOutput("t2_idle", 32'(symValid), 32'd0);

        // Test 3: SKP_INTERVAL=40 instance, SKP only between TS ordered sets.
        doReset();
        segs = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        applyStimulus(1'b1, 1'b1);
        tick();
        for (int s = 0; s < 8; s++) begin
            if (s == 7) begin
                en = 1'b0;
            end
            for (int i = 0; i < ((segs[s] == 2'd1) ? 4 : 16); i++) begin
                checkOutput($sformatf("t3_seg%0d_sym%0d", s, i), 32'({symK40, sym40}),
                            (segs[s] == 2'd1) ? 32'(expSkp(i))
                                              : 32'(expTs(i, 1'b0, 5'b00011, 1'b0, 8'h5A)));
                tick();
            end
        end
        checkOutput("t3_idle", 32'(symValid40), 32'd0);
        checkOutput("t3_cnt", 32'(tsCnt40), 32'd6);

        // Test 4: en_i dropped mid-OS, OS completes, restart latency.
        doReset();
        applyStimulus(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                en = 1'b0;
            end
            checkOutput($sformatf("t4_sym%0d", i), 32'({symK, sym}),
                        32'(expTs(i, 1'b0, 5'b00011, 1'b0, 8'h5A)));
            tick();
        end
        checkOutput("t4_idle0", 32'(symValid), 32'd0);
        tick();
        checkOutput("t4_idle1", 32'(symValid), 32'd0);
        en = 1'b1;
        tick();
        checkOutput("t4_restart_com", 32'({symK, sym}), 32'h1BC);
        checkOutput("t4_restart_valid", 32'(symValid), 32'd1);

        // Test 5: TS counter saturation, type switch restart, clear priority.
        doReset();
        osType = 1'b0;
        applyStimulus(1'b1, 1'b1);
        tick();
        for (int d = 1; d <= 1030; d++) begin
            waitDone("t5_done");
            if (d == 1024) begin
                checkOutput("t5_cnt_1023", 32'(tsCnt), 32'd1023);
                checkOutput("t5_notdone_1023", 32'(tsCntDone), 32'd0);
            end
            tick();
            if (d == 1024) begin
                checkOutput("t5_cnt_1024", 32'(tsCnt), 32'd1024);
                checkOutput("t5_cntdone_1024", 32'(tsCntDone), 32'd1);
            end
        end
        checkOutput("t5_cnt_sat", 32'(tsCnt), 32'd1024);
        checkOutput("t5_cntdone_sat", 32'(tsCntDone), 32'd1);
        osType = 1'b1;
        waitDone("t5_ts2_done");
        tick();
        checkOutput("t5_ts2_restart", 32'(tsCnt), 32'd1);
        checkOutput("t5_ts2_cntdone", 32'(tsCntDone), 32'd0);
        waitDone("t5_clr_done");
        cntClr = 1'b1;
        tick();
        cntClr = 1'b0;
        checkOutput("t5_clr_wins", 32'(tsCnt), 32'd0);

        // Test 6: reset mid-OS aborts, then a fresh COM follows.
        doReset();
        osType = 1'b0;
        applyStimulus(1'b1, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        checkOutput("t6_cnt_before", 32'(tsCnt), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        checkOutput("t6_sym9", 32'({symK, sym}), 32'h04A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_valid",   32'(symValid),  32'd0);
        checkOutput("t6_sym",     32'(sym),       32'd0);
        checkOutput("t6_k",       32'(symK),      32'd0);
        checkOutput("t6_done",    32'(osDone),    32'd0);
        checkOutput("t6_cnt",     32'(tsCnt),     32'd0);
        checkOutput("t6_cntdone", 32'(tsCntDone), 32'd0);
        tick();
        checkOutput("t6_fresh_com", 32'({symK, sym}), 32'h1BC);
        checkOutput("t6_fresh_valid", 32'(symValid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
